// File: rtl/uart_rx_frontend.sv
// UART receive front end: fractional-N oversample clock, RX synchroniser,
// 3-sample majority filter, and break / idle line detection.
module uart_rx_frontend #(
   parameter int unsigned CLK_HZ     = 24000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned OVS        = 12,
   parameter int unsigned ACC_W      = 24,
   parameter int unsigned BREAK_BITS = 20,
   parameter int unsigned IDLE_BITS  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic rx_pin,
   output logic uart_clk,
   output logic tick,
   output logic rx,
   output logic brk,
   output logic line_idle
);

   // Rounded phase increment: round(2^ACC_W * BAUD * OVS / CLK_HZ)
   localparam longint unsigned INC_L =
      (((64'd1 << ACC_W) * 64'(BAUD) * 64'(OVS) * 64'd2) + 64'(CLK_HZ)) / (64'd2 * 64'(CLK_HZ));
   localparam logic [ACC_W-1:0] INC = ACC_W'(INC_L);

   localparam int unsigned BRK_MAX  = BREAK_BITS * OVS;
   localparam int unsigned IDLE_MAX = IDLE_BITS * OVS;
   localparam int unsigned BRK_W    = $clog2(BRK_MAX + 1);
   localparam int unsigned IDLE_W   = $clog2(IDLE_MAX + 1);

   // Reject increments that give no clock or that exceed half the accumulator range
   if (INC_L == 64'd0 || INC_L >= (64'd1 << (ACC_W - 1))) begin : g_bad_inc
      $error("uart_rx_frontend: phase increment out of range");
   end

   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_next_c;
   logic              rise_c;
   logic              fall_c;
   logic              s1;
   logic              s2;
   logic [1:0]        prev;
   logic [2:0]        window_c;
   logic              vote_c;
   logic [BRK_W-1:0]  low_cnt;
   logic [IDLE_W-1:0] high_cnt;

   // Next accumulator phase and the clock edge it produces at this clk edge
   always_comb begin
      acc_next_c = acc + INC;
      rise_c     = ~uart_clk & acc_next_c[ACC_W-1];
      fall_c     = uart_clk & ~acc_next_c[ACC_W-1];
   end

   // Majority over the two previous fall samples plus the one being taken now
   always_comb begin
      window_c = {prev, s2};
      vote_c   = (window_c[0] & window_c[1]) | (window_c[0] & window_c[2]) |
                 (window_c[1] & window_c[2]);
   end

   // Phase accumulator; uart_clk tracks its MSB, tick marks the cycle it rises
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc      <= '0;
         uart_clk <= 1'b0;
         tick     <= 1'b0;
      end else begin
         acc      <= acc_next_c;
         uart_clk <= acc_next_c[ACC_W-1];
         tick     <= rise_c;
      end
   end

   // Two-flop synchroniser on the raw pin
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= rx_pin;
         s2 <= s1;
      end
   end

   // Sample on falling uart_clk so rx is settled well before the consumer's rising edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev <= 2'b11;
         rx   <= 1'b1;
      end else if (fall_c) begin
         prev <= window_c[1:0];
         rx   <= vote_c;
      end
   end

   // Saturating run-length counters of rx level, evaluated on rising uart_clk
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         low_cnt   <= '0;
         high_cnt  <= '0;
         brk       <= 1'b0;
         line_idle <= 1'b0;
      end else if (rise_c) begin
         if (rx) begin
            low_cnt <= '0;
            brk     <= 1'b0;
            if (high_cnt != IDLE_W'(IDLE_MAX)) begin
               high_cnt <= high_cnt + IDLE_W'(1);
            end
            line_idle <= (high_cnt >= IDLE_W'(IDLE_MAX - 1));
         end else begin
            high_cnt  <= '0;
            line_idle <= 1'b0;
            if (low_cnt != BRK_W'(BRK_MAX)) begin
               low_cnt <= low_cnt + BRK_W'(1);
            end
            brk <= (low_cnt >= BRK_W'(BRK_MAX - 1));
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: behavioural phase/sample model compared every cycle,
// plus directed literal checks on clock period, idle/break timing and reset.
module tb_uart_rx_frontend;

   localparam longint unsigned INC     = 64'd966368;
   localparam longint unsigned ACC_MOD = 64'd1 << 24;
   localparam longint unsigned HALF    = 64'd1 << 23;
   localparam int              BRK_N   = 240;
   localparam int              IDLE_N  = 120;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic rx_pin = 1'b1;
   logic uart_clk, tick, rx, brk, line_idle;

   int checks = 0;
   int errors = 0;

   // Model state
   longint unsigned k;
   bit m_uclk, m_tick, m_s1, m_s2, m_rx, m_brk, m_idle;
   bit win [3];
   int lows, highs;

   uart_rx_frontend dut (
      .clk       (clk),
      .reset     (reset),
      .rx_pin    (rx_pin),
      .uart_clk  (uart_clk),
      .tick      (tick),
      .rx        (rx),
      .brk       (brk),
      .line_idle (line_idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      k = 0;
      m_uclk = 0; m_tick = 0; m_s1 = 1; m_s2 = 1; m_rx = 1;
      win[0] = 1; win[1] = 1; win[2] = 1;
      lows = 0; highs = 0; m_brk = 0; m_idle = 0;
   endtask

   // One clk edge of the reference: phase = k*INC mod 2^24, clock high in upper half
   task automatic model_edge(input bit pin);
      longint unsigned ph;
      bit nu, rise, fall;
      int ones;
      k++;
      ph   = (k * INC) % ACC_MOD;
      nu   = (ph >= HALF);
      rise = nu && !m_uclk;
      fall = !nu && m_uclk;
      if (fall) begin
         win[2] = win[1]; win[1] = win[0]; win[0] = m_s2;
         ones = int'(win[0]) + int'(win[1]) + int'(win[2]);
         m_rx = (ones >= 2);
      end
      if (rise) begin
         if (m_rx) begin
            lows = 0;
            highs = (highs < IDLE_N) ? highs + 1 : IDLE_N;
         end else begin
            highs = 0;
            lows = (lows < BRK_N) ? lows + 1 : BRK_N;
         end
         m_brk  = (lows == BRK_N);
         m_idle = (highs == IDLE_N);
      end
      m_tick = rise;
      m_uclk = nu;
      m_s2   = m_s1;
      m_s1   = pin;
   endtask

   task automatic compare();
      check("uart_clk", 32'(uart_clk), 32'(m_uclk));
      check("tick", 32'(tick), 32'(m_tick));
      check("rx", 32'(rx), 32'(m_rx));
      check("brk", 32'(brk), 32'(m_brk));
      check("line_idle", 32'(line_idle), 32'(m_idle));
      check("brk_idle_exclusive", 32'(brk & line_idle), 32'd0);
   endtask

   // Enter at a negedge, drive pin, cross one posedge, check, return at the next negedge
   task automatic step(input bit pin);
      rx_pin = pin;
      @(posedge clk);
      #1;
      if (reset) model_edge(pin);
      compare();
      @(negedge clk);
   endtask

   task automatic wait_tick(input bit pin, input int budget);
      int n;
      n = 0;
      do begin
         step(pin);
         n++;
      end while (!tick && n < budget);
      if (!tick) check("wait_tick_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int n, rises, idle_at, last, total, first, lowrise, brk_at;
      bit rx_min, idle_min, seen;

      model_reset();
      repeat (3) @(negedge clk);
      // Reset state
      check("rst_uart_clk", 32'(uart_clk), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_rx", 32'(rx), 32'd1);
      check("rst_brk", 32'(brk), 32'd0);
      check("rst_idle", 32'(line_idle), 32'd0);

      // First rise after release: 9th clk edge
      reset = 1'b1;
      n = 0;
      do begin step(1'b1); n++; end while (!tick && n < 40);
      check("first_rise_clk", 32'(n), 32'd9);

      // Period statistics over 1000 periods, then idle detection with pin held high
      rises = 1; idle_at = 0; last = n; first = n; total = 0; n = 0;
      while (rises < 1500 && n < 30000) begin
         step(1'b1);
         n++;
         if (tick) begin
            rises++;
            if (rises <= 1001) begin
               check("period_17_or_18", 32'((n + first - last == 17) || (n + first - last == 18)), 32'd1);
               if (rises == 1001) total = n + first - first;
            end
            last = n + first;
         end
         if (line_idle && idle_at == 0) idle_at = rises;
      end
      check("1500_rises_reached", 32'(rises), 32'd1500);
      check("mean_period_window", 32'(total >= 17351 && total <= 17371), 32'd1);
      check("idle_on_rise_120", 32'(idle_at), 32'd120);
      check("rx_high_after_idle", 32'(rx), 32'd1);

      // One-period low glitch centred on a single fall sample
      wait_tick(1'b1, 40);
      rx_min = 1; idle_min = 1;
      repeat (17) begin step(1'b0); rx_min &= rx; idle_min &= line_idle; end
      repeat (60) begin step(1'b1); rx_min &= rx; idle_min &= line_idle; end
      check("glitch_rx_kept", 32'(rx_min), 32'd1);
      check("glitch_idle_kept", 32'(idle_min), 32'd1);

      // Three-period low pulse passes the filter
      wait_tick(1'b1, 40);
      rx_min = 1; idle_min = 1;
      repeat (52) begin step(1'b0); rx_min &= rx; idle_min &= line_idle; end
      repeat (80) begin step(1'b1); rx_min &= rx; idle_min &= line_idle; end
      check("pulse_rx_low", 32'(rx_min), 32'd0);
      check("pulse_idle_drop", 32'(idle_min), 32'd0);
      check("pulse_rx_back", 32'(rx), 32'd1);

      // 21+ bit times low: break on the 240th rise with rx low, saturating
      lowrise = 0; brk_at = 0;
      repeat (4500) begin
         step(1'b0);
         if (tick && !rx) lowrise++;
         if (brk && brk_at == 0) brk_at = lowrise;
      end
      check("brk_on_rise_240", 32'(brk_at), 32'd240);
      check("brk_held_saturated", 32'(brk), 32'd1);
      n = 0; seen = 0;
      while (brk && n < 400) begin
         step(1'b1);
         n++;
         if (!brk) seen = tick && rx;
      end
      check("brk_clear_on_rx1_rise", 32'(seen), 32'd1);
      repeat (300) step(1'b1);

      // Async reset while in break
      n = 0;
      while (!brk && n < 5000) begin step(1'b0); n++; end
      check("brk_before_reset", 32'(brk), 32'd1);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check("async_uart_clk", 32'(uart_clk), 32'd0);
      check("async_brk", 32'(brk), 32'd0);
      check("async_idle", 32'(line_idle), 32'd0);
      check("async_rx", 32'(rx), 32'd1);
      @(negedge clk);
      repeat (4) step(1'b1);
      reset = 1'b1;
      n = 0;
      do begin step(1'b1); n++; end while (!tick && n < 40);
      check("rerelease_first_rise_clk", 32'(n), 32'd9);

      // Randomised line activity: glitches, short bits and long holds
      for (int seg = 0; seg < 300; seg++) begin
         bit lvl;
         int len;
         lvl = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 19) == 0) ? 300 : int'($urandom_range(1, 45));
         repeat (len) step(lvl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
